// File: rtl/cu_edge_data_write_command_control.sv
// cu_edge_data_write_command_control: queues accumulated vertex results and issues them as tagged
// write commands, with bus arbitration, back-pressure and an outstanding-write limit.
module cu_edge_data_write_command_control #(
    parameter int CU_ID_X         = 1,
    parameter int CU_ID_Y         = 1,
    parameter int FIFO_DEPTH      = 16,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic        clock,
    input  logic        rstn_in,
    input  logic        enabled_in,
    input  logic [63:0] wed_dest_base,
    input  logic [31:0] vertex_target,
    input  logic        result_valid,
    input  logic [31:0] result_index,
    input  logic [31:0] result_data,
    input  logic        cmd_buffer_alfull,
    input  logic        cmd_bus_grant,
    output logic        cmd_bus_request,
    output logic        cmd_valid,
    output logic [63:0] cmd_address,
    output logic [31:0] cmd_data,
    output logic [7:0]  cmd_tag,
    output logic [15:0] cmd_cu_id,
    input  logic        resp_valid,
    output logic [31:0] issued_count,
    output logic [31:0] resp_count,
    output logic        overflow_err,
    output logic        done
);
    localparam int          AW    = $clog2(FIFO_DEPTH);
    localparam int          PW    = AW + 1;
    localparam logic [15:0] CU_ID = {8'(CU_ID_X), 8'(CU_ID_Y)};
    localparam logic [31:0] MAX_O = 32'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_nxt;
    logic        en_r, res_v_r, resp_r, grant_r, alfull_r;
    logic [31:0] idx_r, data_r;
    logic [63:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, count;
    logic [63:0] head;
    logic [31:0] outst, outst_nxt;
    logic [7:0]  tag;
    logic        empty, full, room, pop, push, drop, req_nxt, fin;

    always_ff @(posedge clock or negedge rstn_in) begin
        if (!rstn_in) begin
            en_r     <= 1'b0;
            res_v_r  <= 1'b0;
            resp_r   <= 1'b0;
            grant_r  <= 1'b0;
            alfull_r <= 1'b0;
            idx_r    <= '0;
            data_r   <= '0;
        end else begin
            en_r     <= enabled_in;
            res_v_r  <= en_r & result_valid;
            resp_r   <= en_r & resp_valid;
            grant_r  <= cmd_bus_grant;
            alfull_r <= cmd_buffer_alfull;
            idx_r    <= result_index;
            data_r   <= result_data;
        end
    end

    assign count = wr_ptr - rd_ptr;
    assign empty = count == '0;
    assign full  = count == PW'(FIFO_DEPTH);
    assign head  = mem[rd_ptr[AW-1:0]];
    assign room  = outst < MAX_O;
    assign fin   = resp_count == vertex_target && vertex_target != '0 && outst == '0;
    assign done  = state == DONE;

    // A pop frees its slot in the same cycle, so a full FIFO still accepts a concurrent push.
    always_comb begin
        pop       = state == RUN && en_r && grant_r && !alfull_r && room && !empty;
        push      = res_v_r && (!full || pop);
        drop      = en_r && res_v_r && full && !pop;
        req_nxt   = state == RUN && en_r && !empty && !alfull_r && room;
        outst_nxt = (pop && !resp_r) ? outst + 32'd1 :
                    (resp_r && !pop && outst != '0) ? outst - 32'd1 : outst;
        state_nxt = !en_r ? IDLE :
                    state == IDLE ? RUN :
                    (state == RUN && fin) ? DONE : state;
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {idx_r, data_r};
    end

    always_ff @(posedge clock or negedge rstn_in) begin
        if (!rstn_in) begin
            state           <= IDLE;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            outst           <= '0;
            tag             <= '0;
            issued_count    <= '0;
            resp_count      <= '0;
            overflow_err    <= 1'b0;
            cmd_bus_request <= 1'b0;
            cmd_valid       <= 1'b0;
            cmd_address     <= '0;
            cmd_data        <= '0;
            cmd_tag         <= '0;
            cmd_cu_id       <= '0;
        end else begin
            state           <= state_nxt;
            overflow_err    <= overflow_err | drop;
            cmd_bus_request <= req_nxt;
            cmd_valid       <= pop;
            if (pop) begin
                cmd_address <= wed_dest_base + {30'd0, head[63:32], 2'b00};
                cmd_data    <= head[31:0];
                cmd_tag     <= tag;
                cmd_cu_id   <= CU_ID;
            end
            // Leaving enable clears the job but keeps the sticky overflow flag.
            if (!en_r) begin
                wr_ptr       <= '0;
                rd_ptr       <= '0;
                outst        <= '0;
                tag          <= '0;
                issued_count <= '0;
                resp_count   <= '0;
            end else begin
                wr_ptr       <= wr_ptr + PW'(push);
                rd_ptr       <= rd_ptr + PW'(pop);
                outst        <= outst_nxt;
                tag          <= tag + 8'(pop);
                issued_count <= issued_count + 32'(pop);
                resp_count   <= resp_count + 32'(resp_r);
            end
        end
    end
endmodule
